scratchpad_loader: RTL

- Boot sequencer for the tile's ITIM/DTIM scratchpad.
- Holds the core in reset, optionally zero-fills the scratchpad, and streams an image into it over a valid/ready word stream.
- Then enables scratchpad mode and releases core reset after a fixed delay.
- Arbitrates the single scratchpad write port: the loader owns it while loading, the core owns it in RUN.

---
 rtl/scratchpad_loader_pkg.sv | 23 ++
 rtl/scratchpad_port_mux.sv | 50 +++++
 rtl/scratchpad_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/scratchpad_loader_pkg.sv
// scratchpad_loader_pkg: types and constants shared by the scratchpad boot
// sequencer and its write-port mux.
//   state_t        sequencer states
//   ADDR_W_DEF     default word-address width (4096-word scratchpad)
//   DATA_W_DEF     default word width
//   MASK_ALL_ONES  full-word byte mask at the default width
package scratchpad_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MASK_W_DEF = DATA_W_DEF / 8;

    localparam logic [MASK_W_DEF-1:0] MASK_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/scratchpad_port_mux.sv
// scratchpad_port_mux: combinational owner select for the single scratchpad
// write port.
//   core_gnt            1 = core owns the port (pure passthrough of core_*)
//   ld_req/addr/wdata   loader write; always a full-word write
//   core_*              core access, ignored unless core_gnt
//   mem_*               scratchpad port; all zero when nobody drives it
module scratchpad_port_mux
    import scratchpad_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                core_gnt,
    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_wdata,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wmask,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask
);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (core_gnt) begin
            mem_req   = core_req;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_wmask = core_wmask;
        end else if (ld_req) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_wmask = '1;
        end
    end

endmodule

// File: rtl/scratchpad_loader.sv
// scratchpad_loader: boot sequencer for the tile ITIM/DTIM scratchpad. Holds
// the core in reset, optionally zero-fills the scratchpad, streams an image in
// over a valid/ready word stream, enables scratchpad mode and releases core
// reset after a fixed delay. In RUN the core owns the scratchpad port.
//
// Ports:
//   clock, reset            clock, async active-high reset
//   start, len              start pulse, image length in words (latched)
//   s_valid/s_ready/s_data  image word stream
//   core_*                  core scratchpad access, core_gnt when it owns the port
//   mem_*                   scratchpad write port
//   core_reset              reset to the core
//   scratchpad_on           scratchpad mode enable to frontend/dcache
//   busy, done, err         in-progress, RUN-entry pulse, sticky error
//
// Build option SCRATCHPAD_LOADER_CHECKSUM_EN: LOAD takes one trailer word after
// the image that must equal the modulo-2^DATA_W sum of the image words; a
// mismatch sets err and drops back to IDLE with the core still in reset.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | core held in reset, waiting for start
// ST_CLEAR   | zero-filling every scratchpad word, one per cycle
// ST_LOAD    | accepting image words (and trailer when checksummed)
// ST_RELEASE | scratchpad mode on, core still in reset for the delay
// ST_RUN     | core out of reset and owning the scratchpad port
module scratchpad_loader
    import scratchpad_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned RELEASE_CYCLES = 5,
    parameter int unsigned CLEAR_ON_START = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wmask,
    output logic                core_gnt,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic                core_reset,
    output logic                scratchpad_on,
    output logic                busy,
    output logic                done,
    output logic                err
);

    // Width holds RELEASE_CYCLES and stays at least one bit when it is zero.
    localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 2);

    localparam logic [ADDR_W:0]  DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [REL_W-1:0] REL_LOAD  = REL_W'(RELEASE_CYCLES);
    localparam logic [REL_W-1:0] REL_ONE   = REL_W'(1);

    // With a checksum trailer an empty image still passes through LOAD.
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
    localparam bit SKIP_EMPTY = 1'b0;
`else
    localparam bit SKIP_EMPTY = 1'b1;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic                err_q, err_d;
    logic                run_seen_q;
    logic                ld_req;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_wdata;
    logic                grant;
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            rel_q      <= '0;
            err_q      <= 1'b0;
            run_seen_q <= 1'b0;
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            rel_q      <= rel_d;
            err_q      <= err_d;
            run_seen_q <= (state_q == ST_RUN);
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        rel_d    = rel_q;
        err_d    = err_q;
        ld_req   = 1'b0;
        ld_addr  = '0;
        ld_wdata = '0;
        s_ready  = 1'b0;
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    len_d = (len > DEPTH) ? DEPTH : len;
                    err_d = (len > DEPTH);
                    cnt_d = '0;
                    rel_d = REL_LOAD;
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
                    sum_d = '0;
`endif
                    if (CLEAR_ON_START != 0)
                        state_d = ST_CLEAR;
                    else if (SKIP_EMPTY && (len_d == '0))
                        state_d = ST_RELEASE;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_CLEAR: begin
                ld_req  = 1'b1;
                ld_addr = cnt_q[ADDR_W-1:0];
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = (SKIP_EMPTY && (len_q == '0)) ? ST_RELEASE : ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
`ifdef SCRATCHPAD_LOADER_CHECKSUM_EN
                    if (cnt_q != len_q) begin
                        ld_req   = 1'b1;
                        ld_addr  = cnt_q[ADDR_W-1:0];
                        ld_wdata = s_data;
                        sum_d    = sum_q + s_data;
                        cnt_d    = cnt_q + CNT_ONE;
                    end else if (s_data == sum_q) begin
                        state_d = ST_RELEASE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
`else
                    ld_req   = 1'b1;
                    ld_addr  = cnt_q[ADDR_W-1:0];
                    ld_wdata = s_data;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE)
                        state_d = ST_RELEASE;
`endif
                end
            end
            ST_RELEASE: begin
                // A zero delay still spends the single RELEASE cycle.
                if (rel_q <= REL_ONE)
                    state_d = ST_RUN;
                else
                    rel_d = rel_q - REL_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant         = (state_q == ST_RUN);
    assign core_gnt      = grant;
    assign core_reset    = !grant;
    assign scratchpad_on = (state_q == ST_RELEASE) || grant;
    assign busy          = (state_q == ST_CLEAR) || (state_q == ST_LOAD) || (state_q == ST_RELEASE);
    assign done          = grant && !run_seen_q;
    assign err           = err_q;

    scratchpad_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .core_gnt   (grant),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_wmask (core_wmask),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask)
    );

endmodule
